codec_init_sequencer: RTL and testbench
=======================================

CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the WM8731 7-bit I2C device address driven on i2c_addr.
REQ-002 SHALL have parameter GAP_CYCLES, default 500, the idle clk cycles between consecutive register writes.
REQ-003 SHALL have parameter MAX_RETRY, default 3, the retries per register after NACK.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, the watchdog limit (used only under REQ-027).
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports: clk  in  1  system clock (50 MHz).
REQ-007 SHALL have ports: reset  in  1  async active-high reset.
REQ-008 SHALL have ports: start  in  1  one-cycle pulse that begins the init sequence.
REQ-009 SHALL have ports: i2c_req  out  1  write request to the I2C controller.
REQ-010 SHALL have ports: i2c_addr  out  7  device address (DEV_ADDR).
REQ-011 SHALL have ports: i2c_data  out  16  {reg_addr[6:0], reg_val[8:0]}.
REQ-012 SHALL have ports: i2c_ack  in  1  controller accepted the request.
REQ-013 SHALL have ports: i2c_done  in  1  one-cycle pulse at transaction end.
REQ-014 SHALL have ports: i2c_nack  in  1  valid with i2c_done; slave NACKed.
REQ-015 SHALL have ports: busy, init_done, init_error  out  1 each; reg_index  out  4  current table entry.

Function
REQ-016 SHALL use states IDLE, LOAD, REQ, WAIT, GAP, DONE, ERROR.
REQ-017 SHALL ignore start in LOAD/REQ/WAIT/GAP; start in IDLE/DONE/ERROR -> LOAD, reg_index=0, retry count=0, init_done/init_error cleared.
REQ-018 SHALL in LOAD register table entry reg_index onto i2c_data (one cycle), then enter REQ.
REQ-019 SHALL in REQ hold i2c_req=1 with i2c_addr/i2c_data stable until i2c_ack sampled 1, then drop i2c_req the next cycle and enter WAIT.
REQ-020 SHALL treat i2c_done in the same cycle as i2c_ack as a completed transaction (skip WAIT).
REQ-021 SHALL on i2c_done with i2c_nack=0: if reg_index==10 -> DONE, else reg_index+1, retry=0, -> GAP.
REQ-022 SHALL on i2c_done with i2c_nack=1: if retry<MAX_RETRY, retry+1, -> GAP (same index); else -> ERROR.
REQ-023 SHALL in GAP count GAP_CYCLES clk cycles then enter LOAD; GAP_CYCLES=0 goes directly to LOAD.
REQ-024 SHALL assert busy in LOAD/REQ/WAIT/GAP; init_done=1 only in DONE; init_error=1 only in ERROR.
REQ-025 SHALL use the fixed 11-entry table: R15=0x000, R0=0x017, R1=0x017, R2=0x079, R3=0x079, R4=0x012, R5=0x000, R6=0x000, R7=0x002, R8=0x000, R9=0x001 (ACTIVE last).

Reset
REQ-026 SHALL on reset (any state, including mid-transaction) go to IDLE immediately; i2c_req=0, i2c_data=0, i2c_addr=DEV_ADDR, busy=0, init_done=0, init_error=0, reg_index=0, counters=0.

Configuration
REQ-027 SHALL with CODEC_INIT_TIMEOUT_EN defined count cycles in REQ+WAIT per transaction and enter ERROR when TIMEOUT_CYCLES is reached; without it there is no watchdog and the block waits indefinitely.

Structure
REQ-028 SHALL place state enum, table depth (11), register address constants, and the init table in shared package codec_pkg.
REQ-029 SHALL implement the GAP/timeout counter as sub-module cycle_timer (load, enable, expired).

Verification
REQ-030 SHALL cover: start, model acks in 2 cycles, done 20 cycles later with no NACK -> 11 transactions, i2c_data sequence 0x1E00,0x0017,...,0x1201, then init_done=1.
REQ-031 SHALL cover: NACK on entry 4 twice, then ok -> entry 4 sent 3 times, init_done=1.
REQ-032 SHALL cover: NACK on entry 2 four times (MAX_RETRY=3) -> init_error=1, busy=0, reg_index=2.
REQ-033 SHALL cover: reset asserted while i2c_req=1 on entry 5 -> i2c_req=0 same cycle; after start, sequence restarts at 0x1E00.
REQ-034 SHALL cover: i2c_ack and i2c_done in same cycle, plus start pulsed while busy -> no stall, start ignored.
REQ-035 SHALL cover: with CODEC_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=1000, no i2c_done -> init_error=1 after 1000 cycles.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared definitions for the WM8731 init sequencer: FSM states, table depth,
// register addresses and the fixed power-up register table.
package codec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT,
        GAP,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned TABLE_DEPTH = 11;
    localparam logic [3:0]  LAST_INDEX  = 4'(TABLE_DEPTH - 1);

    localparam logic [6:0] REG_LLIN   = 7'h00;
    localparam logic [6:0] REG_RLIN   = 7'h01;
    localparam logic [6:0] REG_LHP    = 7'h02;
    localparam logic [6:0] REG_RHP    = 7'h03;
    localparam logic [6:0] REG_APATH  = 7'h04;
    localparam logic [6:0] REG_DPATH  = 7'h05;
    localparam logic [6:0] REG_PWR    = 7'h06;
    localparam logic [6:0] REG_IFACE  = 7'h07;
    localparam logic [6:0] REG_SRATE  = 7'h08;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    // Entry word is {reg_addr[6:0], reg_val[8:0]}; ACTIVE must be written last.
    function automatic logic [15:0] init_entry(input logic [3:0] idx);
        logic [15:0] w_entry;
        w_entry = '0;
        case (idx)
            4'd0:    w_entry = {REG_RESET,  9'h000};
            4'd1:    w_entry = {REG_LLIN,   9'h017};
            4'd2:    w_entry = {REG_RLIN,   9'h017};
            4'd3:    w_entry = {REG_LHP,    9'h079};
            4'd4:    w_entry = {REG_RHP,    9'h079};
            4'd5:    w_entry = {REG_APATH,  9'h012};
            4'd6:    w_entry = {REG_DPATH,  9'h000};
            4'd7:    w_entry = {REG_PWR,    9'h000};
            4'd8:    w_entry = {REG_IFACE,  9'h002};
            4'd9:    w_entry = {REG_SRATE,  9'h000};
            4'd10:   w_entry = {REG_ACTIVE, 9'h001};
            default: w_entry = '0;
        endcase
        return w_entry;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counter shared by the inter-write gap and the transaction watchdog.
// o_expired is high while the count sits at zero.
module cycle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the WM8731 register table, issuing one I2C write per entry with NACK retry.
// Define CODEC_INIT_TIMEOUT_EN to add a per-transaction watchdog on REQ+WAIT.
module codec_init_sequencer
    import codec_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h1A,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [6:0]  i2c_addr,
    output logic [15:0] i2c_data,
    input  logic        i2c_ack,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        init_done,
    output logic        init_error,
    output logic [3:0]  reg_index
);

    localparam int unsigned TMR_MAX  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW       = $clog2(TMR_MAX + 2);
    localparam int unsigned RW       = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
`ifdef CODEC_INIT_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
`endif

    state_t          r_state,  w_state_nxt;
    logic [3:0]      r_index,  w_index_nxt;
    logic [RW-1:0]   r_retry,  w_retry_nxt;
    logic [15:0]     r_data,   w_data_nxt;
    logic            w_complete;
    logic            w_go_gap;
    logic            w_tmr_load;
    logic [TW-1:0]   w_tmr_val;
    logic            w_tmr_en;
    logic            w_tmr_expired;

    cycle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_index <= '0;
            r_retry <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_retry <= w_retry_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_retry_nxt = r_retry;
        w_data_nxt  = r_data;
        w_complete  = 1'b0;
        w_go_gap    = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = GAP_LOAD;
        w_tmr_en    = 1'b0;

        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            LOAD: begin
                w_data_nxt  = init_entry(r_index);
                w_state_nxt = REQ;
`ifdef CODEC_INIT_TIMEOUT_EN
                w_tmr_load  = 1'b1;
                w_tmr_val   = TO_LOAD;
`endif
            end
            REQ: begin
                // A done coincident with ack finishes the write without visiting WAIT.
                if (i2c_ack) begin
                    if (i2c_done) w_complete  = 1'b1;
                    else          w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i2c_done) w_complete = 1'b1;
            end
            GAP: begin
                if (w_tmr_expired) w_state_nxt = LOAD;
                else               w_tmr_en    = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_complete) begin
            if (!i2c_nack) begin
                if (r_index == LAST_INDEX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_index_nxt = r_index + 4'd1;
                    w_retry_nxt = '0;
                    w_go_gap    = 1'b1;
                end
            end else if (r_retry < RW'(MAX_RETRY)) begin
                w_retry_nxt = r_retry + RW'(1);
                w_go_gap    = 1'b1;
            end else begin
                w_state_nxt = ERROR;
            end
        end
`ifdef CODEC_INIT_TIMEOUT_EN
        else if ((r_state == REQ) || (r_state == WAIT)) begin
            if (w_tmr_expired) w_state_nxt = ERROR;
            else               w_tmr_en    = 1'b1;
        end
`endif

        if (w_go_gap) begin
            if (GAP_CYCLES == 0) begin
                w_state_nxt = LOAD;
            end else begin
                w_state_nxt = GAP;
                w_tmr_load  = 1'b1;
                w_tmr_val   = GAP_LOAD;
            end
        end
    end

    assign i2c_req    = (r_state == REQ);
    assign i2c_addr   = DEV_ADDR;
    assign i2c_data   = r_data;
    assign busy       = (r_state == LOAD) || (r_state == REQ) || (r_state == WAIT) || (r_state == GAP);
    assign init_done  = (r_state == DONE);
    assign init_error = (r_state == ERROR);
    assign reg_index  = r_index;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Randomized bench for codec_init_sequencer: an I2C controller responder plus a
// transaction-list scoreboard built from the register table and retry rules.
module tb_codec_init_sequencer;

    localparam int unsigned GAP   = 5;
    localparam int unsigned MAXR  = 3;
    localparam int unsigned TO    = 1000;
    localparam logic [6:0]  ADDR  = 7'h1A;
    localparam int unsigned BUDGET = 6000;

    logic        clk = 1'b0;
    logic        reset, start, i2c_ack, i2c_done, i2c_nack;
    logic        i2c_req, busy, init_done, init_error;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_data;
    logic [3:0]  reg_index;

    codec_init_sequencer #(
        .DEV_ADDR      (ADDR),
        .GAP_CYCLES    (GAP),
        .MAX_RETRY     (MAXR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .i2c_req   (i2c_req),
        .i2c_addr  (i2c_addr),
        .i2c_data  (i2c_data),
        .i2c_ack   (i2c_ack),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .busy      (busy),
        .init_done (init_done),
        .init_error(init_error),
        .reg_index (reg_index)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register table as (register number, 9-bit value) pairs in write order.
    int unsigned reg_num[11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int unsigned reg_val[11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                                 'h000, 'h000, 'h002, 'h000, 'h001};

    function automatic logic [15:0] entry_word(input int unsigned e);
        return 16'(reg_num[e] * 512 + reg_val[e]);
    endfunction

    typedef struct {
        logic [15:0] data;
        logic        nack;
        int          entry;
    } txn_t;

    txn_t        exp_q[$];
    int unsigned plan[11];
    bit          exp_err;
    int unsigned exp_final;

    task automatic clear_plan();
        foreach (plan[e]) plan[e] = 0;
    endtask

    // plan[e] = number of NACKs the responder gives entry e before accepting it.
    task automatic build_expect();
        txn_t t;
        int unsigned attempts;
        exp_q.delete();
        exp_err   = 1'b0;
        exp_final = 10;
        for (int unsigned e = 0; e < 11; e++) begin
            attempts = (plan[e] > MAXR) ? MAXR + 1 : plan[e] + 1;
            for (int unsigned a = 0; a < attempts; a++) begin
                t.data  = entry_word(e);
                t.nack  = (a < plan[e]);
                t.entry = int'(e);
                exp_q.push_back(t);
            end
            if (plan[e] > MAXR) begin
                exp_err   = 1'b1;
                exp_final = e;
                break;
            end
        end
    endtask

    // mode 0: random latencies, 1: ack after 2 / done 20 later, 2: ack+done immediately.
    task automatic run_seq(input int mode, input bit noise, input int abort_entry);
        int unsigned n = 0, phase = 0, ack_lat = 0, done_lat = 0, gap_cnt = 0, cyc = 0;
        bit          gap_pending = 1'b0, after_ack = 1'b0, first = 1'b0, fin;
        logic [15:0] held = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1'b1);
        while (1) begin
            if (cyc >= BUDGET) begin
                check_eq("run_reached_end", phase, 3);
                return;
            end
            cyc++;
            i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; start = 1'b0;
            fin = 1'b0;
            if (noise && busy && ($urandom_range(7, 0) == 0)) start = 1'b1;
            if (after_ack) begin
                check_eq("req_drop", i2c_req, 1'b0);
                after_ack = 1'b0;
            end
            if (phase == 3) begin
                check_eq("init_done", init_done, !exp_err);
                check_eq("init_error", init_error, exp_err);
                check_eq("busy_end", busy, 1'b0);
                check_eq("final_index", reg_index, exp_final);
                return;
            end
            if (phase == 0) begin
                if (i2c_req) begin
                    if (gap_pending) check_eq("gap_len", gap_cnt, GAP + 1);
                    gap_pending = 1'b0;
                    check_eq("txn_data", i2c_data, exp_q[n].data);
                    check_eq("dev_addr", i2c_addr, ADDR);
                    check_eq("txn_index", reg_index, exp_q[n].entry);
                    if (exp_q[n].entry == abort_entry) begin
                        reset = 1'b1;
                        start = 1'b0;
                        #1;
                        check_eq("rst_req", i2c_req, 1'b0);
                        check_eq("rst_data", i2c_data, 16'h0);
                        check_eq("rst_busy", busy, 1'b0);
                        check_eq("rst_index", reg_index, 4'd0);
                        check_eq("rst_flags", {init_done, init_error}, 2'b00);
                        @(negedge clk);
                        reset = 1'b0;
                        return;
                    end
                    held    = i2c_data;
                    ack_lat = (mode == 0) ? $urandom_range(3, 0) : (mode == 1) ? 2 : 0;
                    first   = 1'b1;
                    phase   = 1;
                end else begin
                    gap_cnt++;
                end
            end
            if (phase == 1) begin
                if (!first) begin
                    check_eq("req_hold", i2c_req, 1'b1);
                    check_eq("data_hold", i2c_data, held);
                end
                first = 1'b0;
                if (ack_lat == 0) begin
                    i2c_ack   = 1'b1;
                    after_ack = 1'b1;
                    done_lat  = (mode == 0) ? $urandom_range(24, 0) : (mode == 1) ? 20 : 0;
                    if (done_lat == 0) fin = 1'b1;
                    else               phase = 2;
                end else begin
                    ack_lat--;
                end
            end else if (phase == 2) begin
                done_lat--;
                if (done_lat == 0) fin = 1'b1;
            end
            if (fin) begin
                i2c_done    = 1'b1;
                i2c_nack    = exp_q[n].nack;
                n++;
                gap_cnt     = 0;
                gap_pending = (n < exp_q.size());
                phase       = (n < exp_q.size()) ? 0 : 3;
            end
            @(negedge clk);
        end
    endtask

`ifdef CODEC_INIT_TIMEOUT_EN
    task automatic run_timeout();
        int unsigned cyc = 0, cnt = 0;
        bit          seen = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!init_error && (cyc < 3 * TO)) begin
            i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
            if (i2c_req) seen = 1'b1;
            if (seen && (cnt == 2)) i2c_ack = 1'b1;
            @(negedge clk);
            if (seen) cnt++;
            cyc++;
        end
        check_eq("timeout_error", init_error, 1'b1);
        check_eq("timeout_cycles", cnt, TO);
        check_eq("timeout_busy", busy, 1'b0);
        check_eq("timeout_index", reg_index, 4'd0);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0;
        i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_req", i2c_req, 1'b0);
        check_eq("reset_data", i2c_data, 16'h0);
        check_eq("reset_addr", i2c_addr, ADDR);
        check_eq("reset_status", {busy, init_done, init_error}, 3'b000);
        check_eq("reset_index", reg_index, 4'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_no_start", {busy, i2c_req}, 2'b00);

        clear_plan(); build_expect(); run_seq(1, 1'b0, -1);
        clear_plan(); plan[4] = 2; build_expect(); run_seq(0, 1'b0, -1);
        clear_plan(); plan[2] = 4; build_expect(); run_seq(0, 1'b0, -1);
        clear_plan(); build_expect(); run_seq(0, 1'b0, 5);
        clear_plan(); build_expect(); run_seq(0, 1'b0, -1);
        clear_plan(); plan[7] = 1; plan[10] = 3; build_expect(); run_seq(2, 1'b1, -1);
        for (int r = 0; r < 8; r++) begin
            foreach (plan[e]) plan[e] = ($urandom_range(9, 0) < 8) ? 0 : $urandom_range(4, 1);
            build_expect();
            run_seq(0, 1'b1, -1);
        end
`ifdef CODEC_INIT_TIMEOUT_EN
        run_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
